// File: rtl/fp12_pkg.sv
// Shared fp12 field definitions and pack/unpack helpers for the divide datapath.
// Packed layout is {sign, exp, man}, exponent bias 15, hidden leading 1 not stored.
package fp12_pkg;

   localparam int unsigned EXP_W   = 5;
   localparam int unsigned MAN_W   = 6;
   localparam int unsigned BIAS    = 15;
   localparam int unsigned EXP_MAX = 31;
   localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp12_t;

   // Normalized quotient waiting for rounding.
   typedef struct packed {
      logic              sign;
      logic signed [6:0] exp;
      logic [MAN_W-1:0]  frac;
      logic              guard;
      logic              sticky;
   } norm_t;

   typedef struct packed {
      logic  ovf;
      logic  unf;
      fp12_t data;
   } res_t;

   function automatic logic [FP_W-1:0] fp12_pack(input fp12_t f);
      return {f.sign, f.exp, f.man};
   endfunction

   function automatic fp12_t fp12_unpack(input logic [FP_W-1:0] bits);
      fp12_t f;
      f.sign = bits[FP_W-1];
      f.exp  = bits[FP_W-2 -: EXP_W];
      f.man  = bits[MAN_W-1:0];
      return f;
   endfunction

endpackage

// File: rtl/fp12_pipe_slice.sv
// Single valid/ready register slice with full throughput.
// Accepts whenever empty or the held word is leaving this cycle.
module fp12_pipe_slice #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_ready) begin
         valid_q <= in_valid;
         // Data held when nothing new arrives so outputs stay quiet.
         if (in_valid) begin
            data_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/fp12_div_normalize.sv
// Post-divide normalize (stage 1) and round-nearest-even / range check (stage 2)
// for the fp12 divider, as a two-slice valid/ready pipeline.
module fp12_div_normalize
   import fp12_pkg::*;
#(
   parameter bit OVF_SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic signed [6:0] in_exp,
   input  logic [8:0]        in_q,
   input  logic              in_sticky,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP_W-1:0]   out_data,
   output logic              out_ovf,
   output logic              out_unf
);

   norm_t             norm_d, norm_q;
   res_t              res_d, res_q;
   logic              s1_valid, s2_ready;
   logic [MAN_W:0]    frac_sum;
   logic [MAN_W-1:0]  frac_r;
   logic signed [6:0] exp_r;
   logic              round_up;

   always_comb begin
      norm_d      = '0;
      norm_d.sign = in_sign;
      if (in_q[8]) begin
         norm_d.frac   = in_q[7:2];
         norm_d.guard  = in_q[1];
         norm_d.sticky = in_q[0] | in_sticky;
         norm_d.exp    = in_exp;
      end else begin
         norm_d.frac   = in_q[6:1];
         norm_d.guard  = in_q[0];
         norm_d.sticky = in_sticky;
         norm_d.exp    = in_exp - 7'sd1;
      end
   end

   fp12_pipe_slice #(
      .WIDTH($bits(norm_t))
   ) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (norm_d),
      .out_valid(s1_valid),
      .out_ready(s2_ready),
      .out_data (norm_q)
   );

   always_comb begin
      round_up = norm_q.guard & (norm_q.sticky | norm_q.frac[0]);
      frac_sum = {1'b0, norm_q.frac} + {{MAN_W{1'b0}}, round_up};
      // Mantissa carry renormalizes to 1.0 in the next binade.
      if (frac_sum[MAN_W]) begin
         frac_r = '0;
         exp_r  = norm_q.exp + 7'sd1;
      end else begin
         frac_r = frac_sum[MAN_W-1:0];
         exp_r  = norm_q.exp;
      end

      res_d           = '0;
      res_d.data.sign = norm_q.sign;
      if (exp_r >= $signed(7'(EXP_MAX))) begin
         res_d.ovf = 1'b1;
         if (OVF_SATURATE) begin
            res_d.data.exp = EXP_W'(EXP_MAX - 1);
            res_d.data.man = '1;
         end else begin
            res_d.data.exp = EXP_W'(EXP_MAX);
         end
      end else if (exp_r <= 7'sd0) begin
         res_d.unf = 1'b1;
      end else begin
         res_d.data.exp = exp_r[EXP_W-1:0];
         res_d.data.man = frac_r;
      end
   end

   fp12_pipe_slice #(
      .WIDTH($bits(res_t))
   ) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (s1_valid),
      .in_ready (s2_ready),
      .in_data  (res_d),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (res_q)
   );

   assign out_data = fp12_pack(res_q.data);
   assign out_ovf  = res_q.ovf;
   assign out_unf  = res_q.unf;

endmodule
